// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM: counting mode and counter direction.
// Imported by the top level; the channel slice needs none of it.
package pwm_pkg;

    typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;

    typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output slice: compares the shared count against this channel's duty
// value, applies polarity, and registers the result.
module pwm_channel #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_cnt,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_polarity,
    output logic             o_pwm
);

    logic w_raw;
    logic r_pwm;

    // When disabled the raw level is forced low, so the pin rests at its polarity.
    assign w_raw = i_en && (i_cnt < i_value);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= w_raw ^ i_polarity;
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: one shared period counter (edge or center aligned) with
// double-buffered range/duty/mode that only take effect at a period boundary.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pwm_en,
    input  logic [WIDTH-1:0]          pwm_range,
    input  logic [CHANNELS*WIDTH-1:0] pwm_value,
    input  logic                      pwm_mode,
    input  logic [CHANNELS-1:0]       pwm_polarity,
    input  logic                      pwm_load,
    output logic                      pwm_load_pending,
    output logic                      pwm_period,
    output logic [CHANNELS-1:0]       pwm_out
);

    typedef struct packed {
        logic [WIDTH-1:0]                range;
        pwm_mode_e                       mode;
        logic [CHANNELS-1:0][WIDTH-1:0]  value;
    } pwm_set_t;

    pwm_set_t         r_stage;
    pwm_set_t         r_active;
    logic [WIDTH-1:0] r_cnt;
    pwm_dir_e         r_dir;
    logic             r_pending;
    logic             r_period;

    logic [WIDTH-1:0] w_next_cnt;
    pwm_dir_e         w_next_dir;
    logic             w_wrap;
    logic             w_apply;

    // Center mode with R=0 would have no down leg, so it falls back to edge counting.
    always_comb begin
        w_next_cnt = r_cnt + WIDTH'(1);
        w_next_dir = r_dir;
        if (r_active.mode == PWM_CENTER && r_active.range != '0) begin
            if (r_dir == DIR_UP) begin
                if (r_cnt == r_active.range) begin
                    w_next_cnt = r_cnt - WIDTH'(1);
                    w_next_dir = (r_active.range == WIDTH'(1)) ? DIR_UP : DIR_DOWN;
                end
            end else begin
                w_next_cnt = r_cnt - WIDTH'(1);
                if (r_cnt == WIDTH'(1)) begin
                    w_next_dir = DIR_UP;
                end
            end
        end else if (r_cnt == r_active.range) begin
            w_next_cnt = '0;
        end
    end

    assign w_wrap  = pwm_en && (w_next_cnt == '0);
    assign w_apply = r_pending && (w_wrap || !pwm_en);

    // A load on the applying edge lands in stage after the copy, so it stays pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_dir     <= DIR_UP;
            r_stage   <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_period  <= 1'b0;
        end else begin
            if (pwm_en) begin
                r_cnt <= w_next_cnt;
                r_dir <= w_next_dir;
            end else begin
                r_cnt <= '0;
                r_dir <= DIR_UP;
            end
            r_period <= pwm_en && (r_cnt == '0);
            if (w_apply) begin
                r_active <= r_stage;
            end
            if (pwm_load) begin
                r_stage.range <= pwm_range;
                r_stage.mode  <= pwm_mode_e'(pwm_mode);
                r_stage.value <= pwm_value;
                r_pending     <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_channel (
            .i_clk      (clk),
            .i_rst_n    (reset),
            .i_en       (pwm_en),
            .i_cnt      (r_cnt),
            .i_value    (r_active.value[gi]),
            .i_polarity (pwm_polarity[gi]),
            .o_pwm      (pwm_out[gi])
        );
    end

    assign pwm_load_pending = r_pending;
    assign pwm_period       = r_period;

endmodule
